// File: rtl/wb_dbg_pkg.sv
// Shared constants for the ext-IO Wishbone debug responder: register offsets,
// CTRL/STATUS bit positions and the default ID value.
package wb_dbg_pkg;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4D57_4442;

  localparam int unsigned OFF_ID       = 0;
  localparam int unsigned OFF_CTRL     = 1;
  localparam int unsigned OFF_STATUS   = 2;
  localparam int unsigned OFF_BP_ADDR  = 3;
  localparam int unsigned OFF_BP_MASK  = 4;
  localparam int unsigned OFF_SCRATCH  = 5;
  localparam int unsigned OFF_CYCLE_LO = 6;
  localparam int unsigned OFF_CYCLE_HI = 7;

  localparam int unsigned CTRL_HALT_BIT = 0;
  localparam int unsigned CTRL_STEP_BIT = 1;
  localparam int unsigned CTRL_BPEN_BIT = 2;

  localparam int unsigned STATUS_HALTED_BIT = 0;
  localparam int unsigned STATUS_BPHIT_BIT  = 1;

endpackage

// File: rtl/wb_dbg_bp_match.sv
// PC breakpoint: masked address compare feeding a sticky hit flag.
// A hit in the same cycle as a write-1-to-clear keeps the flag set.
module wb_dbg_bp_match (
  input  logic        ext_clk,
  input  logic        ext_rst_n,
  input  logic        bp_en,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  input  logic [31:0] bp_addr,
  input  logic [31:0] bp_mask,
  input  logic        clr,
  output logic        bp_hit
);

  logic match;
  logic bp_hit_reg;
  logic bp_hit_next;

  assign match = bp_en & pc_valid & (((pc ^ bp_addr) & bp_mask) == 32'd0);

  always_comb begin
    bp_hit_next = bp_hit_reg;
    if (match) begin
      bp_hit_next = 1'b1;
    end else if (clr) begin
      bp_hit_next = 1'b0;
    end
  end

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      bp_hit_reg <= 1'b0;
    end else begin
      bp_hit_reg <= bp_hit_next;
    end
  end

  assign bp_hit = bp_hit_reg;

endmodule

// File: rtl/wb_ext_dbg_responder.sv
// Pipelined Wishbone debug register bank on the ext-IO bus (ID, CTRL, STATUS, breakpoint, scratch).
// Define WB_DBG_CYCLE_COUNTER_EN to add the 64-bit CYCLE_LO/CYCLE_HI counter at offsets 6/7.
module wb_ext_dbg_responder
  import wb_dbg_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = ID_VALUE_DEFAULT,
  parameter int unsigned ADDR_BITS = 3
) (
  input  logic        ext_clk,
  input  logic        ext_rst_n,
  input  logic [29:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic        wb_dev_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  input  logic        halted_i,
  output logic        halt_req_o,
  output logic        step_o,
  output logic        bp_hit_o
);

  localparam logic [ADDR_BITS-1:0] A_ID      = ADDR_BITS'(OFF_ID);
  localparam logic [ADDR_BITS-1:0] A_CTRL    = ADDR_BITS'(OFF_CTRL);
  localparam logic [ADDR_BITS-1:0] A_STATUS  = ADDR_BITS'(OFF_STATUS);
  localparam logic [ADDR_BITS-1:0] A_BP_ADDR = ADDR_BITS'(OFF_BP_ADDR);
  localparam logic [ADDR_BITS-1:0] A_BP_MASK = ADDR_BITS'(OFF_BP_MASK);
  localparam logic [ADDR_BITS-1:0] A_SCRATCH = ADDR_BITS'(OFF_SCRATCH);

  logic [ADDR_BITS-1:0] reg_idx;
  logic                 accept;
  logic                 wr_en;
  logic                 rd_en;
  logic                 wr_ctrl;
  logic                 wr_status;
  logic                 wr_bp_addr;
  logic                 wr_bp_mask;
  logic                 wr_scratch;
  logic                 unused_adr;

  logic        ctrl_halt_reg, ctrl_halt_next;
  logic        ctrl_bpen_reg, ctrl_bpen_next;
  logic        step_reg, step_next;
  logic        ack_reg;
  logic [31:0] dat_reg, dat_next;
  logic [31:0] bp_addr_reg, bp_addr_next;
  logic [31:0] bp_mask_reg, bp_mask_next;
  logic [31:0] scratch_reg, scratch_next;
  logic [31:0] rd_data;
  logic        bp_clr;
  logic        bp_hit;

  // Only the low ADDR_BITS select a register; everything above aliases.
  assign reg_idx    = wb_adr_i[ADDR_BITS-1:0];
  assign unused_adr = ^wb_adr_i[29:ADDR_BITS];

  assign accept     = wb_cyc_i & wb_stb_i & wb_dev_sel_i;
  assign wr_en      = accept & wb_we_i;
  assign rd_en      = accept & ~wb_we_i;
  assign wb_stall_o = 1'b0;

  assign wr_ctrl    = wr_en & (reg_idx == A_CTRL);
  assign wr_status  = wr_en & (reg_idx == A_STATUS);
  assign wr_bp_addr = wr_en & (reg_idx == A_BP_ADDR);
  assign wr_bp_mask = wr_en & (reg_idx == A_BP_MASK);
  assign wr_scratch = wr_en & (reg_idx == A_SCRATCH);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign bp_addr_next[8*gi +: 8] = (wr_bp_addr & wb_sel_i[gi]) ? wb_dat_i[8*gi +: 8]
                                                                 : bp_addr_reg[8*gi +: 8];
    assign bp_mask_next[8*gi +: 8] = (wr_bp_mask & wb_sel_i[gi]) ? wb_dat_i[8*gi +: 8]
                                                                 : bp_mask_reg[8*gi +: 8];
    assign scratch_next[8*gi +: 8] = (wr_scratch & wb_sel_i[gi]) ? wb_dat_i[8*gi +: 8]
                                                                 : scratch_reg[8*gi +: 8];
  end

  // All CTRL and STATUS control bits live in byte lane 0.
  assign ctrl_halt_next = (wr_ctrl & wb_sel_i[0]) ? wb_dat_i[CTRL_HALT_BIT] : ctrl_halt_reg;
  assign ctrl_bpen_next = (wr_ctrl & wb_sel_i[0]) ? wb_dat_i[CTRL_BPEN_BIT] : ctrl_bpen_reg;
  assign step_next      = wr_ctrl & wb_sel_i[0] & wb_dat_i[CTRL_STEP_BIT] & halted_i;
  assign bp_clr         = wr_status & wb_sel_i[0] & wb_dat_i[STATUS_BPHIT_BIT];

`ifdef WB_DBG_CYCLE_COUNTER_EN
  localparam logic [ADDR_BITS-1:0] A_CYCLE_LO = ADDR_BITS'(OFF_CYCLE_LO);
  localparam logic [ADDR_BITS-1:0] A_CYCLE_HI = ADDR_BITS'(OFF_CYCLE_HI);

  logic [63:0] cycle_reg;
  logic [31:0] cycle_hi_snap_reg;

  // Reading LO latches HI so a LO-then-HI pair is coherent across a low-half wrap.
  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      cycle_reg         <= 64'd0;
      cycle_hi_snap_reg <= 32'd0;
    end else begin
      cycle_reg <= cycle_reg + 64'd1;
      if (rd_en && (reg_idx == A_CYCLE_LO)) begin
        cycle_hi_snap_reg <= cycle_reg[63:32];
      end
    end
  end
`endif

  always_comb begin
    rd_data = 32'd0;
    case (reg_idx)
      A_ID:      rd_data = ID_VALUE;
      A_CTRL: begin
        rd_data[CTRL_HALT_BIT] = ctrl_halt_reg;
        rd_data[CTRL_BPEN_BIT] = ctrl_bpen_reg;
      end
      A_STATUS: begin
        rd_data[STATUS_HALTED_BIT] = halted_i;
        rd_data[STATUS_BPHIT_BIT]  = bp_hit;
      end
      A_BP_ADDR: rd_data = bp_addr_reg;
      A_BP_MASK: rd_data = bp_mask_reg;
      A_SCRATCH: rd_data = scratch_reg;
`ifdef WB_DBG_CYCLE_COUNTER_EN
      A_CYCLE_LO: rd_data = cycle_reg[31:0];
      A_CYCLE_HI: rd_data = cycle_hi_snap_reg;
`endif
      default:   rd_data = 32'd0;
    endcase
  end

  assign dat_next = rd_en ? rd_data : 32'd0;

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      ctrl_halt_reg <= 1'b0;
      ctrl_bpen_reg <= 1'b0;
      step_reg      <= 1'b0;
      ack_reg       <= 1'b0;
      dat_reg       <= 32'd0;
      bp_addr_reg   <= 32'd0;
      bp_mask_reg   <= 32'd0;
      scratch_reg   <= 32'd0;
    end else begin
      ctrl_halt_reg <= ctrl_halt_next;
      ctrl_bpen_reg <= ctrl_bpen_next;
      step_reg      <= step_next;
      ack_reg       <= accept;
      dat_reg       <= dat_next;
      bp_addr_reg   <= bp_addr_next;
      bp_mask_reg   <= bp_mask_next;
      scratch_reg   <= scratch_next;
    end
  end

  wb_dbg_bp_match u_bp_match (
    .ext_clk   (ext_clk),
    .ext_rst_n (ext_rst_n),
    .bp_en     (ctrl_bpen_reg),
    .pc        (pc_i),
    .pc_valid  (pc_valid_i),
    .bp_addr   (bp_addr_reg),
    .bp_mask   (bp_mask_reg),
    .clr       (bp_clr),
    .bp_hit    (bp_hit)
  );

  // A master that drops cyc before the response aborts it.
  assign wb_ack_o   = ack_reg & wb_cyc_i;
  assign wb_dat_o   = wb_ack_o ? dat_reg : 32'd0;
  assign halt_req_o = ctrl_halt_reg | bp_hit;
  assign step_o     = step_reg;
  assign bp_hit_o   = bp_hit;

endmodule

// File: tb/tb_wb_ext_dbg_responder.sv
// Bench for wb_ext_dbg_responder: directed cases plus random bus/PC traffic against a register-level model.
module tb_wb_ext_dbg_responder;

  logic        ext_clk = 1'b0;
  logic        ext_rst_n = 1'b1;
  logic [29:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic        wb_dev_sel_i = 1'b1;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_stall_o;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        halted_i = 1'b0;
  logic        halt_req_o;
  logic        step_o;
  logic        bp_hit_o;

  always #5 ext_clk = ~ext_clk;

  wb_ext_dbg_responder dut (
    .ext_clk      (ext_clk),
    .ext_rst_n    (ext_rst_n),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_sel_i     (wb_sel_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_we_i      (wb_we_i),
    .wb_dev_sel_i (wb_dev_sel_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o),
    .wb_stall_o   (wb_stall_o),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .halted_i     (halted_i),
    .halt_req_o   (halt_req_o),
    .step_o       (step_o),
    .bp_hit_o     (bp_hit_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural register contents plus the one outstanding response.
  logic        m_halt, m_bpen, m_bphit, m_step;
  logic [31:0] m_bp_addr, m_bp_mask, m_scratch;
  logic        p_valid, p_we, p_dc;
  logic [31:0] p_data;
  int          p_off;
  logic [31:0] last_dat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_halt = 0; m_bpen = 0; m_bphit = 0; m_step = 0;
    m_bp_addr = 0; m_bp_mask = 0; m_scratch = 0;
    p_valid = 0; p_we = 0; p_dc = 0; p_data = 0; p_off = 0;
  endtask

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0:       return 32'h4D57_4442;
      1:       return {29'd0, m_bpen, 1'b0, m_halt};
      2:       return {30'd0, m_bphit, halted_i};
      3:       return m_bp_addr;
      4:       return m_bp_mask;
      5:       return m_scratch;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (sel[b]) res[8*b +: 8] = dat[8*b +: 8];
    return res;
  endfunction

  // One bus cycle: inputs already driven; check at negedge, advance model, return at posedge+1.
  task automatic tick();
    logic acc, hit, exp_ack, clr;
    int   off;
    @(negedge ext_clk);
    exp_ack = p_valid & wb_cyc_i;
    chk("ack", 32'(wb_ack_o), 32'(exp_ack));
    if (exp_ack) begin
      last_dat = wb_dat_o;
      if (!p_dc) chk(p_we ? "wr_dat" : "rd_dat", wb_dat_o, p_data);
      $display("txn %s off=%0d dat=%h", p_we ? "wr" : "rd", p_off, wb_dat_o);
    end else begin
      chk("dat_idle", wb_dat_o, 32'd0);
    end
    chk("stall", 32'(wb_stall_o), 32'd0);
    chk("halt_req", 32'(halt_req_o), 32'(m_halt | m_bphit));
    chk("step", 32'(step_o), 32'(m_step));
    chk("bp_hit", 32'(bp_hit_o), 32'(m_bphit));

    acc = wb_cyc_i & wb_stb_i & wb_dev_sel_i;
    off = int'(wb_adr_i[2:0]);
    hit = m_bpen & pc_valid_i & (((pc_i ^ m_bp_addr) & m_bp_mask) == 32'd0);
    p_valid = acc;
    p_we    = wb_we_i;
    p_off   = off;
`ifdef WB_DBG_CYCLE_COUNTER_EN
    p_dc    = acc & ~wb_we_i & (off >= 6);
`else
    p_dc    = 1'b0;
`endif
    p_data  = (acc & ~wb_we_i) ? model_read(off) : 32'd0;
    m_step  = acc & wb_we_i & (off == 1) & wb_sel_i[0] & wb_dat_i[1] & halted_i;
    clr     = acc & wb_we_i & (off == 2) & wb_sel_i[0] & wb_dat_i[1];
    m_bphit = hit | (m_bphit & ~clr);
    if (acc & wb_we_i) begin
      case (off)
        1: if (wb_sel_i[0]) begin m_halt = wb_dat_i[0]; m_bpen = wb_dat_i[2]; end
        3: m_bp_addr = merge(m_bp_addr, wb_dat_i, wb_sel_i);
        4: m_bp_mask = merge(m_bp_mask, wb_dat_i, wb_sel_i);
        5: m_scratch = merge(m_scratch, wb_dat_i, wb_sel_i);
        default: ;
      endcase
    end
    @(posedge ext_clk);
    #1;
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we, input logic [29:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    wb_cyc_i = cyc; wb_stb_i = stb; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    tick();
  endtask

  task automatic rd(input logic [29:0] adr);
    drive(1'b1, 1'b1, 1'b0, adr, 32'd0, 4'd0);
  endtask

  task automatic wr(input logic [29:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    drive(1'b1, 1'b1, 1'b1, adr, dat, sel);
  endtask

  task automatic hold();
    drive(1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 4'd0);
  endtask

  task automatic apply_reset();
    ext_rst_n = 1'b0;
    #2;
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_halt_req", 32'(halt_req_o), 32'd0);
    chk("rst_step", 32'(step_o), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit_o), 32'd0);
    model_reset();
    @(posedge ext_clk);
    #1;
    ext_rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] lo_a;
    model_reset();
    last_dat = 0;
    #1;
    apply_reset();

    // ID read right after reset
    hold();
    rd(30'd0);
    hold();
    chk("id_value", last_dat, 32'h4D57_4442);

    // byte-lane write to SCRATCH
    wr(30'd5, 32'hFFFF_FFFF, 4'b0101);
    rd(30'd5);
    hold();
    chk("scratch_lanes", last_dat, 32'h00FF_00FF);
    wr(30'd5, 32'h1234_5678, 4'b0000);
    rd(30'd5);
    hold();

    // breakpoint hit, then W1C racing another hit
    wr(30'd3, 32'h0000_1000, 4'hF);
    wr(30'd4, 32'hFFFF_FFF0, 4'hF);
    wr(30'd1, 32'h0000_0004, 4'hF);
    pc_i = 32'h0000_100C; pc_valid_i = 1'b1;
    hold();
    hold();
    chk("bp_hit_set", 32'(bp_hit_o), 32'd1);
    wr(30'd2, 32'h0000_0002, 4'h1);
    hold();
    chk("bp_hit_w1c_race", 32'(bp_hit_o), 32'd1);
    pc_valid_i = 1'b0;
    wr(30'd2, 32'h0000_0002, 4'h1);
    rd(30'd2);
    hold();
    chk("bp_hit_cleared", 32'(bp_hit_o), 32'd0);
    wr(30'd1, 32'h0000_0000, 4'hF);

    // step requires halted core; back-to-back writes pulse each time
    halted_i = 1'b0;
    wr(30'd1, 32'h0000_0002, 4'h1);
    hold();
    halted_i = 1'b1;
    wr(30'd1, 32'h0000_0002, 4'h1);
    hold();
    hold();
    wr(30'd1, 32'h0000_0002, 4'h1);
    wr(30'd1, 32'h0000_0002, 4'h1);
    hold();
    hold();
    wr(30'd1, 32'h0000_0002, 4'h2);
    hold();
    halted_i = 1'b0;

    // pipelined reads, then an aborted one
    rd(30'd0);
    rd(30'd5);
    rd(30'd1);
    hold();
    rd(30'd0);
    rd(30'd5);
    drive(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 4'd0);
    hold();

    // aliasing, dev_sel gating, unused offsets
    rd(30'h3FFF_FFF8);
    wb_dev_sel_i = 1'b0;
    rd(30'd0);
    wb_dev_sel_i = 1'b1;
    rd(30'd6);
    rd(30'd7);
    hold();

    // reset with an ack pending
    rd(30'd0);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b0;
    apply_reset();
    hold();

`ifdef WB_DBG_CYCLE_COUNTER_EN
    rd(30'd6);
    hold();
    lo_a = last_dat;
    repeat (9) hold();
    rd(30'd6);
    hold();
    chk("cycle_lo_delta", last_dat - lo_a, 32'd11);
    rd(30'd6);
    rd(30'd7);
    hold();
    chk("cycle_hi_snap", last_dat, 32'd0);
`else
    lo_a = 32'd0;
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      halted_i     = 1'($urandom_range(0, 1));
      pc_valid_i   = 1'($urandom_range(0, 1));
      pc_i         = ($urandom_range(0, 1) != 0) ? (m_bp_addr ^ ($urandom() & ~m_bp_mask))
                                                 : $urandom();
      wb_dev_sel_i = ($urandom_range(0, 7) != 0);
      drive(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            30'($urandom()), $urandom(), 4'($urandom_range(0, 15)));
    end
    hold();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
